// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined WIDTH-bit logic unit with valid/ready handshakes.
//
// Optional feature macro: LOGIC_UNIT_STATS_EN (adds the saturating op_count output).
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set offered
//   in_ready   unit can accept operands this cycle
//   inA, inB   operands (inB ignored for NOT A / PASS A)
//   op         000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 PASS A
//   out_valid  result available
//   out_ready  consumer takes result this cycle
//   out        result
//   out_zero   result is all zeros (registered with out)
//   op_count   accepted operations, saturating (LOGIC_UNIT_STATS_EN only)
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_zero
`ifdef LOGIC_UNIT_STATS_EN
   ,
   output logic [CNT_W-1:0] op_count
`endif
);

   // Elaboration-time parameter sanity checks.
   if (WIDTH < 1) begin : g_bad_width
      $error("logic_unit_pipe: WIDTH must be at least 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("logic_unit_pipe: CNT_W must be at least 1");
   end

   // Stage 1: captured operands
   logic             s1_valid_q;
   logic [WIDTH-1:0] s1_a_q;
   logic [WIDTH-1:0] s1_b_q;
   logic [2:0]       s1_op_q;

   // Stage 2: registered result
   logic             s2_valid_q;
   logic [WIDTH-1:0] s2_res_q;
   logic             s2_zero_q;

   logic             s2_free;
   logic             s1_adv;
   logic             in_xfer;
   logic [WIDTH-1:0] res_d;

   // S2 can take new data if empty or being drained this cycle; in_ready never looks at
   // in_valid so the source cannot form a combinational loop through us.
   assign s2_free  = !s2_valid_q || out_ready;
   assign s1_adv   = s1_valid_q && s2_free;
   assign in_ready = !s1_valid_q || s2_free;
   assign in_xfer  = in_valid && in_ready;

   // Result is computed from S1 contents only.
   always_comb begin
      res_d = '0;
      unique case (s1_op_q)
         3'b000:  res_d = s1_a_q & s1_b_q;
         3'b001:  res_d = s1_a_q | s1_b_q;
         3'b010:  res_d = ~(s1_a_q & s1_b_q);
         3'b011:  res_d = ~(s1_a_q | s1_b_q);
         3'b100:  res_d = s1_a_q ^ s1_b_q;
         3'b101:  res_d = ~(s1_a_q ^ s1_b_q);
         3'b110:  res_d = ~s1_a_q;
         3'b111:  res_d = s1_a_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
      end else if (in_xfer) begin
         s1_valid_q <= 1'b1;
         s1_a_q     <= inA;
         s1_b_q     <= inB;
         s1_op_q    <= op;
      end else if (s1_adv) begin
         s1_valid_q <= 1'b0;
      end
   end

   // S2 only changes on a load or a drain, so out/out_zero hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_zero_q  <= 1'b0;
      end else if (s1_adv) begin
         s2_valid_q <= 1'b1;
         s2_res_q   <= res_d;
         s2_zero_q  <= (res_d == '0);
      end else if (out_ready) begin
         s2_valid_q <= 1'b0;
      end
   end

   assign out_valid = s2_valid_q;
   assign out       = s2_res_q;
   assign out_zero  = s2_zero_q;

`ifdef LOGIC_UNIT_STATS_EN
   logic [CNT_W-1:0] op_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         op_count_q <= '0;
      end else if (in_xfer && (op_count_q != '1)) begin
         op_count_q <= op_count_q + CNT_W'(1);
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed plan items plus a randomized handshake run
// checked against a truth-table reference model and an in-flight result queue.
module tb_logic_unit_pipe;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] inA;
   logic [WIDTH-1:0] inB;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             out_zero;

   logic             n1_in_valid;
   logic             n1_in_ready;
   logic [0:0]       n1_inA;
   logic [0:0]       n1_inB;
   logic [2:0]       n1_op;
   logic             n1_out_valid;
   logic             n1_out_ready;
   logic [0:0]       n1_out;
   logic             n1_out_zero;

`ifdef LOGIC_UNIT_STATS_EN
   logic [CNT_W-1:0] op_count;
   logic [CNT_W-1:0] n1_op_count;
`endif

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inA       (inA),
      .inB       (inB),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_zero  (out_zero)
`ifdef LOGIC_UNIT_STATS_EN
      ,
      .op_count  (op_count)
`endif
   );

   logic_unit_pipe #(.WIDTH(1), .CNT_W(CNT_W)) dut_w1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (n1_in_valid),
      .in_ready  (n1_in_ready),
      .inA       (n1_inA),
      .inB       (n1_inB),
      .op        (n1_op),
      .out_valid (n1_out_valid),
      .out_ready (n1_out_ready),
      .out       (n1_out),
      .out_zero  (n1_out_zero)
`ifdef LOGIC_UNIT_STATS_EN
      ,
      .op_count  (n1_op_count)
`endif
   );

   typedef struct {
      logic [WIDTH-1:0] res;
      int               cyc;
   } item_t;

   item_t            exp_q[$];
   int               n_checks = 0;
   int               n_fail   = 0;
   int               cyc      = 0;
   int               n_acc    = 0;
   logic             stalled  = 1'b0;
   logic [WIDTH-1:0] held_out;
   logic             held_zero;
   logic             lat_chk  = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Each op is a 4-entry truth table indexed by {a,b} per bit.
   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b, input logic [2:0] o);
      logic [3:0]       tt;
      logic [WIDTH-1:0] r;
      case (o)
         3'd0:    tt = 4'b1000;
         3'd1:    tt = 4'b1110;
         3'd2:    tt = 4'b0111;
         3'd3:    tt = 4'b0001;
         3'd4:    tt = 4'b0110;
         3'd5:    tt = 4'b1001;
         3'd6:    tt = 4'b0011;
         default: tt = 4'b1100;
      endcase
      for (int i = 0; i < int'(WIDTH); i++) r[i] = tt[{a[i], b[i]}];
      return r;
   endfunction

   // One clock cycle on the main DUT: drive, sample mid-cycle, check, update model.
   task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] o, input logic ordy, output logic acc);
      logic  exp_rdy;
      item_t it;
      @(negedge clk);
      in_valid  = v;
      inA       = a;
      inB       = b;
      op        = o;
      out_ready = ordy;
      #1;
      // At most two operations can be in flight; a full pipe only blocks when not draining.
      exp_rdy = (exp_q.size() < 2) || ordy;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (stalled) begin
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_out", 32'(out), 32'(held_out));
         check("hold_zero", 32'(out_zero), 32'(held_zero));
      end
      if (out_valid && ordy) begin
         if (exp_q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            it = exp_q.pop_front();
            check("out", 32'(out), 32'(it.res));
            check("out_zero", 32'(out_zero), 32'(it.res == '0));
            if (lat_chk) check("latency", 32'(cyc - it.cyc), 32'd2);
         end
      end
      stalled   = out_valid && !ordy;
      held_out  = out;
      held_zero = out_zero;
`ifdef LOGIC_UNIT_STATS_EN
      check("op_count", 32'(op_count), (n_acc > 3) ? 32'd3 : 32'(n_acc));
`endif
      acc = v && exp_rdy;
      if (acc) begin
         it.res = model(a, b, o);
         it.cyc = cyc;
         exp_q.push_back(it);
         n_acc++;
      end
      cyc++;
   endtask

   // One-cycle reset with operands offered (they must be ignored), then check the reset state.
   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b1;
      inA       = 8'h5A;
      inB       = 8'hC3;
      op        = 3'd1;
      out_ready = 1'b0;
      @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b0;
      exp_q.delete();
      stalled   = 1'b0;
      n_acc     = 0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", 32'(out), 32'd0);
      check("rst_out_zero", 32'(out_zero), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef LOGIC_UNIT_STATS_EN
      check("rst_op_count", 32'(op_count), 32'd0);
`endif
   endtask

   task automatic drain(input int budget);
      logic acc;
      for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle(1'b0, '0, '0, '0, 1'b1, acc);
      check("lost_results", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic             acc;
      logic [WIDTH-1:0] ra, rb, r;
      logic [2:0]       ro;
      logic             pend;
      logic [1:0]       pat_a, pat_b;
      int               idx;

      rst = 1'b1; in_valid = 1'b0; inA = '0; inB = '0; op = '0; out_ready = 1'b0;
      n1_in_valid = 1'b0; n1_inA = '0; n1_inB = '0; n1_op = 3'b010; n1_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      do_reset();

      // WIDTH=1 NAND truth table, inputs (A,B) = 00, 10, 01, 11.
      pat_a = 2'b10;
      pat_b = 2'b01;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n1_in_valid = (i < 4);
         n1_inA      = (i == 1 || i == 3) ? 1'b1 : 1'b0;
         n1_inB      = (i == 2 || i == 3) ? 1'b1 : 1'b0;
         #1;
         check("n1_in_ready", 32'(n1_in_ready), 32'd1);
         if (i < 2) begin
            check("n1_out_valid_early", 32'(n1_out_valid), 32'd0);
         end else begin
            r = model({7'd0, (i == 3 || i == 5) ? 1'b1 : 1'b0},
                      {7'd0, (i == 4 || i == 5) ? 1'b1 : 1'b0}, 3'b010);
            check("n1_out_valid", 32'(n1_out_valid), 32'd1);
            check("n1_nand", 32'(n1_out), 32'(r[0]));
         end
      end
      n1_in_valid = 1'b0;

      // All eight ops back-to-back on F0/3C, exact two-cycle latency.
      lat_chk = 1'b1;
      for (int o = 0; o < 8; o++) cycle(1'b1, 8'hF0, 8'h3C, 3'(o), 1'b1, acc);
      cycle(1'b1, 8'hAA, 8'hAA, 3'b100, 1'b1, acc);
      drain(10);
      lat_chk = 1'b0;

      // Backpressure: three ops offered while out_ready=0, then release.
      idx = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(idx < 3, 8'h11 << idx, 8'h0F, 3'(idx + 1), 1'b0, acc);
         if (acc) idx++;
      end
      for (int i = 0; i < 8; i++) begin
         cycle(idx < 3, 8'h11 << idx, 8'h0F, 3'(idx + 1), 1'b1, acc);
         if (acc) idx++;
      end
      drain(10);

      // Reset with both stages full: nothing stale may come out afterwards.
      cycle(1'b1, 8'h01, 8'h02, 3'd1, 1'b0, acc);
      cycle(1'b1, 8'h03, 8'h04, 3'd1, 1'b0, acc);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0, '0, '0, 1'b1, acc);
         check("post_rst_out_valid", 32'(out_valid), 32'd0);
      end

      // Randomized handshakes; the source holds an unaccepted operand set.
      pend = 1'b0;
      ra = '0; rb = '0; ro = '0;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            pend = ($urandom_range(0, 3) != 0);
            ra   = WIDTH'($urandom);
            rb   = ($urandom_range(0, 7) == 0) ? ra : WIDTH'($urandom);
            ro   = 3'($urandom);
         end
         cycle(pend, ra, rb, ro, $urandom_range(0, 2) != 0, acc);
         if (acc) pend = 1'b0;
      end
      drain(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
